// File: rtl/limb_fetch.sv
// Limb instruction fetch stage: PC, ROM addressing, output slot, return stack.
// Ports: clk, reset (async low), rom_addr/rom_data, instr_valid/instr_ready,
//   instr/instr_pc, redir_valid/kind/target/link, ras_count, fault.
// Macro LIMB_FETCH_FAULT_EN: stack over/underflow traps into FAULT.
module limb_fetch #(
  parameter int PC_W      = 8,
  parameter int INSTR_W   = 32,
  parameter int RAS_DEPTH = 8,
  localparam int IW       = $clog2(RAS_DEPTH),
  localparam int CW       = IW + 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               redir_valid,
  input  logic [1:0]         redir_kind,
  input  logic [PC_W-1:0]    redir_target,
  input  logic [PC_W-1:0]    redir_link,
  output logic [CW-1:0]      ras_count,
  output logic               fault
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FAULT
  } state_t;

  localparam logic [1:0] K_JUMP = 2'd0;
  localparam logic [1:0] K_CALL = 2'd1;
  localparam logic [1:0] K_RET  = 2'd2;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] ras [RAS_DEPTH];

  logic          slot_free;
  logic          do_redir;
  logic          is_full;
  logic          is_empty;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] top_idx;

  assign rom_addr  = pc;
  assign slot_free = !instr_valid || instr_ready;
  assign do_redir  = redir_valid && (redir_kind != 2'd3);
  assign is_full   = (ras_count == CW'(RAS_DEPTH));
  assign is_empty  = (ras_count == '0);
  assign push_idx  = ras_count[IW-1:0];
  // When full the low bits are 0, so this wraps to the last entry.
  assign top_idx   = ras_count[IW-1:0] - IW'(1);

`ifdef LIMB_FETCH_FAULT_EN
  logic stack_err;
  assign stack_err = ((redir_kind == K_CALL) && is_full) ||
                     ((redir_kind == K_RET) && is_empty);
  assign fault = (state == S_FAULT);
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_BOOT;
      pc          <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      ras_count   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++)
        ras[i] <= '0;
    end else begin
      unique case (state)
        S_BOOT: state <= S_RUN;
        S_RUN: begin
          if (do_redir) begin
`ifdef LIMB_FETCH_FAULT_EN
            if (stack_err) begin
              state       <= S_FAULT;
              instr_valid <= 1'b0;
            end else
`endif
            begin
              instr_valid <= 1'b0;
              unique case (redir_kind)
                K_JUMP: pc <= redir_target;
                K_CALL: begin
                  pc <= redir_target;
                  if (is_full) begin
                    ras[top_idx] <= redir_link;
                  end else begin
                    ras[push_idx] <= redir_link;
                    ras_count     <= ras_count + CW'(1);
                  end
                end
                K_RET: begin
                  if (is_empty) begin
                    pc <= '0;
                  end else begin
                    pc        <= ras[top_idx];
                    ras_count <= ras_count - CW'(1);
                  end
                end
                default: ;
              endcase
            end
          end else if (slot_free) begin
            instr       <= rom_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + PC_W'(1);
          end
        end
        S_FAULT: instr_valid <= 1'b0;
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_limb_fetch.sv
// Directed testbench for limb_fetch.
// ROM model returns 32'hABCD_0000 | address.
module tb_limb_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        redir_valid;
  logic [1:0]  redir_kind;
  logic [7:0]  redir_target;
  logic [7:0]  redir_link;
  logic [3:0]  ras_count;
  logic        fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] romw(logic [7:0] a);
    return 32'hABCD_0000 | {24'h0, a};
  endfunction

  assign rom_data = romw(rom_addr);

  limb_fetch dut (
    .clk(clk), .reset(reset),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redir_valid(redir_valid), .redir_kind(redir_kind),
    .redir_target(redir_target), .redir_link(redir_link),
    .ras_count(ras_count), .fault(fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic redir(logic [1:0] k, logic [7:0] t, logic [7:0] l);
    redir_valid  = 1'b1;
    redir_kind   = k;
    redir_target = t;
    redir_link   = l;
  endtask

  task automatic idle();
    redir_valid = 1'b0;
    redir_kind  = 2'd0;
  endtask

  task automatic restart();
    reset = 1'b0;
    #2;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b0;
    instr_ready = 1'b1;
    idle();
    redir_target = '0;
    redir_link = '0;
    tick();
    tick();
    chk("reset_valid", 32'(instr_valid), 32'd0);
    chk("reset_instr", instr, 32'd0);
    chk("reset_pc", 32'(instr_pc), 32'd0);
    chk("reset_ras", 32'(ras_count), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_addr", 32'(rom_addr), 32'd0);

    // Boot then stream A,B,C.
    reset = 1'b1;
    tick();
    chk("boot_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("a_valid", 32'(instr_valid), 32'd1);
    chk("a_instr", instr, romw(8'd0));
    chk("a_pc", 32'(instr_pc), 32'd0);
    tick();
    chk("b_instr", instr, romw(8'd1));
    chk("b_pc", 32'(instr_pc), 32'd1);

    // Stall with B held.
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_instr", instr, romw(8'd1));
      chk("stall_pc", 32'(instr_pc), 32'd1);
      chk("stall_addr", 32'(rom_addr), 32'd2);
    end
    instr_ready = 1'b1;
    tick();
    chk("c_instr", instr, romw(8'd2));
    chk("c_pc", 32'(instr_pc), 32'd2);

    // JUMP while valid.
    redir(2'd0, 8'h40, 8'h00);
    tick();
    idle();
    chk("jmp_bubble", 32'(instr_valid), 32'd0);
    tick();
    chk("jmp_valid", 32'(instr_valid), 32'd1);
    chk("jmp_pc", 32'(instr_pc), 32'h40);
    chk("jmp_instr", instr, romw(8'h40));

    // Wrap from 0xFF.
    redir(2'd0, 8'hFF, 8'h00);
    tick();
    idle();
    tick();
    chk("wrap_ff", 32'(instr_pc), 32'hFF);
    chk("wrap_addr", 32'(rom_addr), 32'h00);
    tick();
    chk("wrap_00", 32'(instr_pc), 32'h00);

    // CALL then RET.
    redir(2'd1, 8'h20, 8'h06);
    tick();
    idle();
    chk("call_ras", 32'(ras_count), 32'd1);
    chk("call_bubble", 32'(instr_valid), 32'd0);
    tick();
    chk("call_pc", 32'(instr_pc), 32'h20);
    redir(2'd2, 8'h00, 8'h00);
    tick();
    idle();
    chk("ret_ras", 32'(ras_count), 32'd0);
    tick();
    chk("ret_pc", 32'(instr_pc), 32'h06);

    // Reserved kind: no flush, fetch continues.
    redir(2'd3, 8'h55, 8'h66);
    tick();
    idle();
    chk("k3_valid", 32'(instr_valid), 32'd1);
    chk("k3_pc", 32'(instr_pc), 32'h07);
    chk("k3_ras", 32'(ras_count), 32'd0);

    // Eight CALLs fill the stack.
    for (int i = 0; i < 8; i++) begin
      redir(2'd1, 8'(8'h30 + i), 8'(8'h10 + i));
      tick();
    end
    chk("full_ras", 32'(ras_count), 32'd8);
    redir(2'd1, 8'h38, 8'h18);
    tick();
    idle();
`ifdef LIMB_FETCH_FAULT_EN
    chk("ovf_fault", 32'(fault), 32'd1);
    chk("ovf_valid", 32'(instr_valid), 32'd0);
    chk("ovf_ras", 32'(ras_count), 32'd8);
    chk("ovf_addr", 32'(rom_addr), 32'h37);
    tick();
    tick();
    chk("flt_valid", 32'(instr_valid), 32'd0);
    chk("flt_fault", 32'(fault), 32'd1);
    chk("flt_addr", 32'(rom_addr), 32'h37);
    restart();
    chk("clr_fault", 32'(fault), 32'd0);
    redir(2'd2, 8'h00, 8'h00);
    tick();
    idle();
    chk("udf_fault", 32'(fault), 32'd1);
    chk("udf_ras", 32'(ras_count), 32'd0);
    tick();
    chk("udf_valid", 32'(instr_valid), 32'd0);
`else
    chk("ovf_fault", 32'(fault), 32'd0);
    chk("ovf_ras", 32'(ras_count), 32'd8);
    tick();
    chk("ovf_pc", 32'(instr_pc), 32'h38);
    redir(2'd2, 8'h00, 8'h00);
    tick();
    idle();
    chk("pop_ras", 32'(ras_count), 32'd7);
    tick();
    chk("top_link", 32'(instr_pc), 32'h18);
    for (int k = 0; k < 7; k++) begin
      redir(2'd2, 8'h00, 8'h00);
      tick();
      idle();
      tick();
      chk("pop_pc", 32'(instr_pc), 32'(8'h16 - k));
    end
    chk("empty_ras", 32'(ras_count), 32'd0);
    redir(2'd2, 8'h00, 8'h00);
    tick();
    idle();
    chk("udf_ras", 32'(ras_count), 32'd0);
    chk("udf_fault", 32'(fault), 32'd0);
    tick();
    chk("udf_pc", 32'(instr_pc), 32'h00);
    chk("udf_instr", instr, romw(8'h00));
`endif

    // Async reset mid-stall with three stack entries.
    restart();
    for (int i = 0; i < 3; i++) begin
      redir(2'd1, 8'(8'h50 + i), 8'(8'h60 + i));
      tick();
    end
    idle();
    tick();
    tick();
    instr_ready = 1'b0;
    tick();
    tick();
    chk("pre_ras", 32'(ras_count), 32'd3);
    chk("pre_valid", 32'(instr_valid), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_instr", instr, 32'd0);
    chk("async_pc", 32'(instr_pc), 32'd0);
    chk("async_ras", 32'(ras_count), 32'd0);
    chk("async_fault", 32'(fault), 32'd0);
    chk("async_addr", 32'(rom_addr), 32'd0);
    tick();
    reset = 1'b1;
    instr_ready = 1'b1;
    tick();
    chk("reboot_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("refetch_valid", 32'(instr_valid), 32'd1);
    chk("refetch_pc", 32'(instr_pc), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
